// File: rtl/regfile_2r1w_clr_pkg.sv
// Shared types for the 2R1W register file with clear engine.
// Clear FSM states and the address-width helper.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_t;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_2r1w_clr_if.sv
// Port bundle of the 2R1W register file: write, two reads, clear.
// The master drives requests; the slave is the register file.
interface regfile_2r1w_clr_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en_a;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_valid_a;
    logic             rd_en_b;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid_b;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;
    logic             wr_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a,
        output rd_en_b, rd_addr_b,
        output clr_req,
        input  rd_data_a, rd_valid_a,
        input  rd_data_b, rd_valid_b,
        input  clr_busy, clr_done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a,
        input  rd_en_b, rd_addr_b,
        input  clr_req,
        output rd_data_a, rd_valid_a,
        output rd_data_b, rd_valid_b,
        output clr_busy, clr_done, wr_err
    );

endinterface

// File: rtl/regfile_2r1w_clr_rd_port.sv
// One registered read port: bypass mux, out-of-range zeroing,
// output data and valid registers.
module regfile_rd_port #(
    parameter int WIDTH  = 32,
    parameter int AW     = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             in_range,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    logic             hit;
    logic [WIDTH-1:0] rd_next;

    // wr_en here is the effective write, clear writes included
    assign hit = BYPASS && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_next = mem_data;
        if (!in_range) begin
            rd_next = '0;
        end else if (hit) begin
            rd_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w_clr.sv
// Parametrised 2R1W register file with write-to-read bypass
// and a background clear engine that zeroes one entry per cycle.
module regfile_2r1w_clr
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input logic          clk,
    input logic          reset,
    regfile_2r1w_clr_if.slave bus
);

    localparam int          AW   = addr_w(DEPTH);
    localparam logic [31:0] LAST = 32'(DEPTH - 1);
    localparam logic [31:0] DEP  = 32'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    clr_state_t       state_q;
    clr_state_t       state_d;
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;
    logic             busy;
    logic             wr_ok;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             wr_err_q;
    logic             in_a;
    logic             in_b;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_b;

    assign busy  = (state_q == CLR_RUN);
    assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < DEP) && !busy;

    // The clear engine owns the write port while it runs
    assign we = busy || wr_ok;
    assign wa = busy ? ptr_q : bus.wr_addr;
    assign wd = busy ? '0 : bus.wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLR_IDLE;
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_err_q <= bus.wr_en && busy;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLR_IDLE, CLR_DONE: begin
                state_d = CLR_IDLE;
                if (bus.clr_req) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end
            end
            CLR_RUN: begin
                // Hold at the last entry so a non-power-of-two depth never wraps
                if (32'(ptr_q) == LAST) begin
                    state_d = CLR_DONE;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = CLR_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign bus.clr_busy = busy;
    assign bus.clr_done = (state_q == CLR_DONE);
    assign bus.wr_err   = wr_err_q;

    assign in_a  = 32'(bus.rd_addr_a) < DEP;
    assign in_b  = 32'(bus.rd_addr_b) < DEP;
    assign mem_a = in_a ? mem[bus.rd_addr_a] : '0;
    assign mem_b = in_b ? mem[bus.rd_addr_b] : '0;

    regfile_rd_port #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .BYPASS(BYPASS)
    ) u_rd_a (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (bus.rd_en_a),
        .rd_addr (bus.rd_addr_a),
        .in_range(in_a),
        .mem_data(mem_a),
        .wr_en   (we),
        .wr_addr (wa),
        .wr_data (wd),
        .rd_data (bus.rd_data_a),
        .rd_valid(bus.rd_valid_a)
    );

    regfile_rd_port #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .BYPASS(BYPASS)
    ) u_rd_b (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (bus.rd_en_b),
        .rd_addr (bus.rd_addr_b),
        .in_range(in_b),
        .mem_data(mem_b),
        .wr_en   (we),
        .wr_addr (wa),
        .wr_data (wd),
        .rd_data (bus.rd_data_b),
        .rd_valid(bus.rd_valid_b)
    );

endmodule
